// File: rtl/csr_arbiter_if.sv
// csr_arbiter_if
// Bundles the two requester ports (core pipeline, debug module) and the
// CSR file access port that csr_arbiter sits between.
//   slave  : the arbiter's view (takes requests, drives grants/responses
//            and the CSR file access inputs)
//   master : the environment's view (requesters plus the CSR file)
interface csr_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int RFLEN = 5,
    parameter int F3W   = 3
);
    // core requester
    logic             core_req;
    logic [XLEN-1:0]  core_addr;
    logic [XLEN-1:0]  core_reg;
    logic [XLEN-1:0]  core_imm;
    logic [RFLEN-1:0] core_rs;
    logic [F3W-1:0]   core_f3;
    logic             core_debug;
    logic             core_flush;
    logic             core_gnt;
    logic             core_rvalid;
    logic             core_err;
    logic [XLEN-1:0]  core_rdata;

    // debug requester
    logic             dbg_req;
    logic [XLEN-1:0]  dbg_addr;
    logic [XLEN-1:0]  dbg_wdata;
    logic             dbg_write;
    logic             dbg_gnt;
    logic             dbg_rvalid;
    logic             dbg_err;
    logic [XLEN-1:0]  dbg_rdata;

    // CSR file access port
    logic [XLEN-1:0]  csr_addr;
    logic [XLEN-1:0]  csr_reg_in;
    logic [XLEN-1:0]  csr_imm_in;
    logic [RFLEN-1:0] csr_rs;
    logic [F3W-1:0]   csr_f3;
    logic             csr_write;
    logic             csr_debug;
    logic [XLEN-1:0]  csr_reg_out;
    logic             csr_illegal;

    modport slave (
        input  core_req, core_addr, core_reg, core_imm, core_rs, core_f3,
               core_debug, core_flush,
        output core_gnt, core_rvalid, core_err, core_rdata,
        input  dbg_req, dbg_addr, dbg_wdata, dbg_write,
        output dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
        output csr_addr, csr_reg_in, csr_imm_in, csr_rs, csr_f3,
               csr_write, csr_debug,
        input  csr_reg_out, csr_illegal
    );

    modport master (
        output core_req, core_addr, core_reg, core_imm, core_rs, core_f3,
               core_debug, core_flush,
        input  core_gnt, core_rvalid, core_err, core_rdata,
        output dbg_req, dbg_addr, dbg_wdata, dbg_write,
        input  dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
        input  csr_addr, csr_reg_in, csr_imm_in, csr_rs, csr_f3,
               csr_write, csr_debug,
        output csr_reg_out, csr_illegal
    );
endinterface

// File: rtl/csr_arbiter.sv
// csr_arbiter
// Shares the single CSR file between the core pipeline (Zicsr) and the
// debug module (abstract-command CSR access). One access per three cycles:
// grant (IDLE) -> CSR access (ACCESS) -> response pulse (RESP).
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    csr_arbiter_if.slave: core/debug request+response ports and the
//          CSR file access port
//
// state  | meaning
// IDLE   | arbitrate; combinational grant, latch winner's fields
// ACCESS | drive csr_write, capture read data / illegal flag
// RESP   | one-cycle rvalid pulse to the owner
module csr_arbiter #(
    parameter int XLEN  = 32,
    parameter int RFLEN = 5,
    parameter int F3W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    csr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [F3W-1:0] F3_CSRRW = F3W'(1);
    localparam logic [F3W-1:0] F3_CSRRS = F3W'(2);

    state_t state, state_nxt;

    logic             owner_dbg;   // 1 = debug module owns the current access
    logic             last_dbg;    // 1 = debug module won the most recent grant
    logic             gnt_core, gnt_dbg, kill;

    logic [XLEN-1:0]  h_addr, h_reg, h_imm;
    logic [RFLEN-1:0] h_rs;
    logic [F3W-1:0]   h_f3;
    logic             h_debug;

    logic [XLEN-1:0]  core_rdata_q, dbg_rdata_q;
    logic             core_err_q, dbg_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_core || gnt_dbg) state_nxt = ACCESS;
            ACCESS:  state_nxt = kill ? IDLE : RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_core        = 1'b0;
        gnt_dbg         = 1'b0;
        // Grants are combinational, so they are qualified with rst_n to
        // stay low while reset is held even if a request is pending.
        if (state == IDLE && rst_n) begin
            // On a tie the requester that did not win last time gets it.
            if (bus.core_req && (!bus.dbg_req || last_dbg)) gnt_core = 1'b1;
            else if (bus.dbg_req)                           gnt_dbg  = 1'b1;
        end
        kill            = (state == ACCESS) && !owner_dbg && bus.core_flush;
        bus.core_gnt    = gnt_core;
        bus.dbg_gnt     = gnt_dbg;
        bus.csr_write   = (state == ACCESS) && !kill;
        bus.core_rvalid = (state == RESP) && !owner_dbg;
        bus.dbg_rvalid  = (state == RESP) && owner_dbg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_dbg    <= 1'b0;
            last_dbg     <= 1'b1;
            h_addr       <= '0;
            h_reg        <= '0;
            h_imm        <= '0;
            h_rs         <= '0;
            h_f3         <= '0;
            h_debug      <= 1'b0;
            core_rdata_q <= '0;
            core_err_q   <= 1'b0;
            dbg_rdata_q  <= '0;
            dbg_err_q    <= 1'b0;
        end else begin
            if (gnt_core) begin
                owner_dbg <= 1'b0;
                last_dbg  <= 1'b0;
                h_addr    <= bus.core_addr;
                h_reg     <= bus.core_reg;
                h_imm     <= bus.core_imm;
                h_rs      <= bus.core_rs;
                h_f3      <= bus.core_f3;
                h_debug   <= bus.core_debug;
            end else if (gnt_dbg) begin
                // Debug reads become CSRRS with rs=0 so the CSR file
                // suppresses the write; debug writes become CSRRW.
                owner_dbg <= 1'b1;
                last_dbg  <= 1'b1;
                h_addr    <= bus.dbg_addr;
                h_reg     <= bus.dbg_write ? bus.dbg_wdata : '0;
                h_imm     <= '0;
                h_rs      <= '0;
                h_f3      <= bus.dbg_write ? F3_CSRRW : F3_CSRRS;
                h_debug   <= 1'b1;
            end
            if (state == ACCESS && !kill) begin
                if (owner_dbg) begin
                    dbg_rdata_q  <= bus.csr_reg_out;
                    dbg_err_q    <= bus.csr_illegal;
                end else begin
                    core_rdata_q <= bus.csr_reg_out;
                    core_err_q   <= bus.csr_illegal;
                end
            end
        end
    end

    assign bus.csr_addr   = h_addr;
    assign bus.csr_reg_in = h_reg;
    assign bus.csr_imm_in = h_imm;
    assign bus.csr_rs     = h_rs;
    assign bus.csr_f3     = h_f3;
    assign bus.csr_debug  = h_debug;
    assign bus.core_rdata = core_rdata_q;
    assign bus.core_err   = core_err_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.dbg_err    = dbg_err_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Testbench for csr_arbiter: a small CSR file stands in for the real one,
// a transaction-level model predicts every output each cycle, and directed
// scenarios add hand-computed expectations.
module tb_csr_arbiter;
    localparam int XLEN  = 32;
    localparam int RFLEN = 5;
    localparam int F3W   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csr_arbiter_if #(.XLEN(XLEN), .RFLEN(RFLEN), .F3W(F3W)) bus ();

    csr_arbiter #(.XLEN(XLEN), .RFLEN(RFLEN), .F3W(F3W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- CSR file stand-in ----------------
    // 0x300 mstatus, 0x340 mscratch, 0x7B0 dcsr (debug-only), 0xF11 mvendorid (read-only)
    logic [31:0] mem [0:3] = '{32'h0000_1800, 32'h0000_00A5, 32'h4000_0003, 32'h0000_0000};

    function automatic int csr_idx(input logic [31:0] a);
        case (a)
            32'h300: return 0;
            32'h340: return 1;
            32'h7B0: return 2;
            32'hF11: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic csr_wr_en(input logic [2:0] f3, input logic [4:0] rs, input logic [31:0] imm);
        if (f3[1:0] == 2'b01) return 1'b1;
        if (f3[1:0] == 2'b00) return 1'b0;
        return f3[2] ? (imm != 0) : (rs != 0);
    endfunction

    function automatic logic csr_bad(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rs,
                                     input logic [31:0] imm, input logic dbgm);
        if (csr_idx(a) < 0) return 1'b1;
        if (csr_wr_en(f3, rs, imm) && a[11:10] == 2'b11) return 1'b1;
        if (a[11:4] == 8'h7B && !dbgm) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] csr_next(input logic [31:0] old, input logic [2:0] f3,
                                             input logic [31:0] rv, input logic [31:0] imm);
        logic [31:0] src;
        src = f3[2] ? imm : rv;
        case (f3[1:0])
            2'b01:   return src;
            2'b10:   return old | src;
            2'b11:   return old & ~src;
            default: return old;
        endcase
    endfunction

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        int i;
        i = csr_idx(a);
        return (i < 0) ? 32'h0 : mem[i];
    endfunction

    always_comb begin
        bus.csr_reg_out = '0;
        for (int i = 0; i < 4; i++)
            if (csr_idx(bus.csr_addr) == i) bus.csr_reg_out = mem[i];
    end

    assign bus.csr_illegal = csr_bad(bus.csr_addr, bus.csr_f3, bus.csr_rs, bus.csr_imm_in, bus.csr_debug);

    always @(posedge clk)
        if (rst_n && bus.csr_write && !bus.csr_illegal && csr_wr_en(bus.csr_f3, bus.csr_rs, bus.csr_imm_in))
            mem[csr_idx(bus.csr_addr)] <= csr_next(mem[csr_idx(bus.csr_addr)], bus.csr_f3,
                                                   bus.csr_reg_in, bus.csr_imm_in);

    // ---------------- transaction-level model ----------------
    // A grant at cycle t means the CSR access happens at t+1 and the
    // response at t+2; the arbiter is free again at t+3 (t+2 if flushed).
    int          cyc     = 0;
    int          t_gnt   = -10;
    bit          alive   = 1'b0;
    bit          own_dbg = 1'b0;
    bit          last_dbg_m = 1'b1;
    logic [31:0] e_addr = 0, e_reg = 0, e_imm = 0;
    logic [4:0]  e_rs = 0;
    logic [2:0]  e_f3 = 0;
    logic        e_debug = 0;
    logic [31:0] e_rd_core = 0, e_rd_dbg = 0;
    logic        e_err_core = 0, e_err_dbg = 0;
    bit          m_free, x_cg, x_dg, x_acc, x_wr, x_crv, x_drv;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ctrl", {bus.core_gnt, bus.dbg_gnt, bus.core_rvalid, bus.dbg_rvalid,
                               bus.core_err, bus.dbg_err, bus.csr_write, bus.csr_debug}, 0);
            check("rst_data", {bus.csr_rs, bus.csr_f3, bus.core_rdata | bus.dbg_rdata | bus.csr_addr
                               | bus.csr_reg_in | bus.csr_imm_in}, 0);
            t_gnt = -10; alive = 0; own_dbg = 0; last_dbg_m = 1;
            e_addr = 0; e_reg = 0; e_imm = 0; e_rs = 0; e_f3 = 0; e_debug = 0;
            e_rd_core = 0; e_rd_dbg = 0; e_err_core = 0; e_err_dbg = 0;
        end else begin
            m_free = (cyc >= t_gnt + (alive ? 3 : 2));
            x_cg   = m_free && bus.core_req && (!bus.dbg_req || last_dbg_m);
            x_dg   = m_free && bus.dbg_req && !x_cg;
            x_acc  = alive && (cyc == t_gnt + 1);
            x_wr   = x_acc && !(!own_dbg && bus.core_flush);
            x_crv  = alive && (cyc == t_gnt + 2) && !own_dbg;
            x_drv  = alive && (cyc == t_gnt + 2) && own_dbg;

            check("core_gnt",    bus.core_gnt,    x_cg);
            check("dbg_gnt",     bus.dbg_gnt,     x_dg);
            check("csr_write",   bus.csr_write,   x_wr);
            check("core_rvalid", bus.core_rvalid, x_crv);
            check("dbg_rvalid",  bus.dbg_rvalid,  x_drv);
            check("csr_fields",  {bus.csr_addr, bus.csr_rs, bus.csr_f3, bus.csr_debug},
                                 {e_addr, e_rs, e_f3, e_debug});
            check("csr_reg_in",  bus.csr_reg_in,  e_reg);
            check("csr_imm_in",  bus.csr_imm_in,  e_imm);
            check("core_resp",   {bus.core_err, bus.core_rdata}, {e_err_core, e_rd_core});
            check("dbg_resp",    {bus.dbg_err, bus.dbg_rdata},   {e_err_dbg, e_rd_dbg});

            if (x_acc) begin
                if (!x_wr) alive = 0;
                else if (own_dbg) begin
                    e_rd_dbg  = mem_at(e_addr);
                    e_err_dbg = csr_bad(e_addr, e_f3, e_rs, e_imm, e_debug);
                end else begin
                    e_rd_core  = mem_at(e_addr);
                    e_err_core = csr_bad(e_addr, e_f3, e_rs, e_imm, e_debug);
                end
            end
            if (x_cg) begin
                t_gnt = cyc; alive = 1; own_dbg = 0; last_dbg_m = 0;
                e_addr = bus.core_addr; e_reg = bus.core_reg; e_imm = bus.core_imm;
                e_rs = bus.core_rs; e_f3 = bus.core_f3; e_debug = bus.core_debug;
            end else if (x_dg) begin
                t_gnt = cyc; alive = 1; own_dbg = 1; last_dbg_m = 1;
                e_addr = bus.dbg_addr; e_reg = bus.dbg_write ? bus.dbg_wdata : 32'h0; e_imm = 0;
                e_rs = 0; e_f3 = bus.dbg_write ? 3'b001 : 3'b010; e_debug = 1;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] s_reg;
    logic [2:0]  s_f3;
    logic [4:0]  s_rs;
    logic        s_wr;
    int          g_wait;

    task automatic core_start(input logic [31:0] addr, input logic [31:0] rv, input logic [31:0] imm,
                              input logic [4:0] rs, input logic [2:0] f3, input logic dbgm);
        @(posedge clk); #1;
        bus.core_req = 1; bus.core_addr = addr; bus.core_reg = rv; bus.core_imm = imm;
        bus.core_rs = rs; bus.core_f3 = f3; bus.core_debug = dbgm;
    endtask

    task automatic dbg_start(input logic [31:0] addr, input logic [31:0] wd, input logic wr);
        @(posedge clk); #1;
        bus.dbg_req = 1; bus.dbg_addr = addr; bus.dbg_wdata = wd; bus.dbg_write = wr;
    endtask

    // Waits (bounded) for the grant, drops the request, records the access
    // cycle's CSR inputs, then waits (bounded) for the response.
    task automatic finish_txn(input bit is_dbg, input string nm, output logic [31:0] rd, output logic err);
        int n;
        n = 0;
        @(negedge clk);
        while (!(is_dbg ? bus.dbg_gnt : bus.core_gnt) && n < 8) begin
            @(negedge clk); n++;
        end
        g_wait = n;
        check({nm, "_gnt_seen"}, is_dbg ? bus.dbg_gnt : bus.core_gnt, 1);
        @(posedge clk); #1;
        if (is_dbg) bus.dbg_req = 0; else bus.core_req = 0;
        n = 0;
        @(negedge clk);
        s_wr = bus.csr_write; s_f3 = bus.csr_f3; s_rs = bus.csr_rs; s_reg = bus.csr_reg_in;
        while (!(is_dbg ? bus.dbg_rvalid : bus.core_rvalid) && n < 8) begin
            @(negedge clk); n++;
        end
        check({nm, "_rvalid_seen"}, is_dbg ? bus.dbg_rvalid : bus.core_rvalid, 1);
        check({nm, "_latency"}, n, 1);
        rd  = is_dbg ? bus.dbg_rdata : bus.core_rdata;
        err = is_dbg ? bus.dbg_err : bus.core_err;
    endtask

    // Both requesters assert together; core reads 0x300, debug reads 0x340.
    task automatic run_pair(input string nm, input logic [31:0] exp_core, input logic [31:0] exp_dbg);
        int cg, cr, dg, dr;
        logic [31:0] crd, drd;
        cg = -1; cr = -1; dg = -1; dr = -1; crd = 0; drd = 0;
        @(posedge clk); #1;
        bus.core_req = 1; bus.core_addr = 32'h300; bus.core_reg = 0; bus.core_imm = 0;
        bus.core_rs = 0; bus.core_f3 = 3'b010; bus.core_debug = 0;
        bus.dbg_req = 1; bus.dbg_addr = 32'h340; bus.dbg_wdata = 0; bus.dbg_write = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.core_gnt) cg = i;
            if (bus.dbg_gnt) dg = i;
            if (bus.core_rvalid) begin cr = i; crd = bus.core_rdata; end
            if (bus.dbg_rvalid) begin dr = i; drd = bus.dbg_rdata; end
            @(posedge clk); #1;
            if (cg == i) bus.core_req = 0;
            if (dg == i) bus.dbg_req = 0;
        end
        check({nm, "_core_gnt_cyc"}, cg, 0);
        check({nm, "_core_rv_cyc"}, cr, 2);
        check({nm, "_dbg_gnt_cyc"}, dg, 3);
        check({nm, "_dbg_rv_cyc"}, dr, 5);
        check({nm, "_core_rdata"}, crd, exp_core);
        check({nm, "_dbg_rdata"}, drd, exp_dbg);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          n;

        bus.core_req = 0; bus.core_addr = 0; bus.core_reg = 0; bus.core_imm = 0;
        bus.core_rs = 0; bus.core_f3 = 0; bus.core_debug = 0; bus.core_flush = 0;
        bus.dbg_req = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0; bus.dbg_write = 0;

        repeat (2) @(negedge clk);
        check("reset_csr_write", bus.csr_write, 0);
        check("reset_dbg_rdata", bus.dbg_rdata, 0);
        #1 rst_n = 1;

        // tie out of reset: core first; tie again after debug wins: core again
        run_pair("tie1", 32'h1800, 32'hA5);
        run_pair("tie2", 32'h1800, 32'hA5);

        // debug read of mstatus
        dbg_start(32'h300, 32'h0, 1'b0);
        finish_txn(1'b1, "dbg_rd", rd, err);
        check("dbg_rd_acc_write", s_wr, 1);
        check("dbg_rd_acc_f3", s_f3, 3'b010);
        check("dbg_rd_acc_rs", s_rs, 0);
        check("dbg_rd_rdata", rd, 32'h1800);
        check("dbg_rd_err", err, 0);
        check("dbg_rd_csr_kept", mem_at(32'h300), 32'h1800);

        // core CSRRW to mscratch
        core_start(32'h340, 32'h5A, 32'h0, 5'd1, 3'b001, 1'b0);
        finish_txn(1'b0, "core_rw", rd, err);
        check("core_rw_acc_reg", s_reg, 32'h5A);
        check("core_rw_rdata", rd, 32'hA5);
        check("core_rw_err", err, 0);
        check("core_rw_csr_new", mem_at(32'h340), 32'h5A);

        // flush during ACCESS kills the core access
        core_start(32'h340, 32'h1234, 32'h0, 5'd1, 3'b001, 1'b0);
        n = 0;
        @(negedge clk);
        while (!bus.core_gnt && n < 8) begin @(negedge clk); n++; end
        check("flush_gnt_seen", bus.core_gnt, 1);
        @(posedge clk); #1;
        bus.core_req = 0; bus.core_flush = 1;
        @(negedge clk);
        check("flush_csr_write", bus.csr_write, 0);
        dbg_start(32'h340, 32'h0, 1'b0);
        bus.core_flush = 0;
        finish_txn(1'b1, "flush_dbg", rd, err);
        check("flush_idle_next", g_wait, 0);
        check("flush_csr_kept", rd, 32'h5A);
        check("flush_csr_mem", mem_at(32'h340), 32'h5A);

        // illegal accesses
        dbg_start(32'hF11, 32'h5, 1'b1);
        finish_txn(1'b1, "dbg_ro", rd, err);
        check("dbg_ro_err", err, 1);
        check("dbg_ro_kept", mem_at(32'hF11), 32'h0);
        dbg_start(32'h7FF, 32'h7, 1'b1);
        finish_txn(1'b1, "dbg_none", rd, err);
        check("dbg_none_err", err, 1);
        core_start(32'h7B0, 32'h0, 32'h0, 5'd0, 3'b010, 1'b0);
        finish_txn(1'b0, "core_dcsr_nodbg", rd, err);
        check("core_dcsr_nodbg_err", err, 1);
        core_start(32'h7B0, 32'h0, 32'h0, 5'd0, 3'b010, 1'b1);
        finish_txn(1'b0, "core_dcsr_dbg", rd, err);
        check("core_dcsr_dbg_err", err, 0);
        check("core_dcsr_dbg_rdata", rd, 32'h4000_0003);
        dbg_start(32'h7B0, 32'h4000_0007, 1'b1);
        finish_txn(1'b1, "dbg_dcsr_wr", rd, err);
        check("dbg_dcsr_wr_err", err, 0);
        check("dbg_dcsr_wr_rdata", rd, 32'h4000_0003);
        check("dbg_dcsr_wr_mem", mem_at(32'h7B0), 32'h4000_0007);

        // reset pulse during ACCESS aborts the access
        core_start(32'h340, 32'hDEAD, 32'h0, 5'd1, 3'b001, 1'b0);
        n = 0;
        @(negedge clk);
        while (!bus.core_gnt && n < 8) begin @(negedge clk); n++; end
        check("rstmid_gnt_seen", bus.core_gnt, 1);
        @(posedge clk); #1;
        bus.core_req = 0;
        #1;
        check("rstmid_in_access", bus.csr_write, 1);
        rst_n = 0;
        #1;
        check("rstmid_write_off", bus.csr_write, 0);
        check("rstmid_addr_off", bus.csr_addr, 0);
        @(negedge clk); #1 rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            check("rstmid_no_rvalid", bus.core_rvalid, 0);
        end
        check("rstmid_csr_kept", mem_at(32'h340), 32'h5A);
        dbg_start(32'h340, 32'h0, 1'b0);
        finish_txn(1'b1, "rstmid_next", rd, err);
        check("rstmid_next_gnt", g_wait, 0);
        check("rstmid_next_rdata", rd, 32'h5A);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
